mdu_issue_ctrl: RTL
===================

// Module: mdu_issue_ctrl
// PURPOSE
//  Initiator side of the multiply/divide unit handshake, between ID and EX.
//  Accepts decoded MDU ops from ID and issues each one to the MDU with a one-cycle start pulse.
//  Models MDU occupancy with a latency counter and stalls ID while a mult/div is in flight.
//  Cancels a just-issued op when an exception or interrupt flush (req) arrives.
// PARAMETERS
//  MUL_LAT  5   busy cycles for MULT/MULTU, counted from the issue cycle inclusive
//  DIV_LAT  10  busy cycles for DIV/DIVU
//  CNT_W    4   latency counter width; must satisfy 2**CNT_W > max(MUL_LAT, DIV_LAT)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      synchronous, active-high
//  id_valid     in   1      ID holds a valid instruction
//  id_op        in   4      MDU op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
//  ex_ready     in   1      EX may accept a new instruction this cycle (no other freeze)
//  req          in   1      exception/interrupt flush
//  issue_start  out  1      start pulse to MDU; already gated with ~req
//  issue_op     out  4      registered op presented to the MDU with issue_start
//  stall_id     out  1      freeze ID/IF
//  busy         out  1      a mult/div is in flight
//  cycles_left  out  CNT_W  remaining busy cycles; 0 when idle
// BEHAVIOUR
//  - Reset: state IDLE; issue_start_q=0, issue_op=0, busy=0, cycles_left=0, stall_id=0.
//  - State machine:
//      IDLE -> BUSY_MUL on accept of op 1/2 (cnt <= MUL_LAT).
//      IDLE -> BUSY_DIV on accept of op 3/4 (cnt <= DIV_LAT).
//      BUSY_* -> IDLE when cnt==1 at the clock edge.
//  - Accept condition: id_valid && id_op!=0 && id_op<=8 && !stall_id && ex_ready && !req.
//  - On accept: at the next edge, issue_start_q<=1 and issue_op<=id_op. Ops 5..8 do not leave IDLE.
//  - issue_start = issue_start_q & ~req (combinational). issue_start_q drops after one cycle unless a new accept occurs.
//  - Busy counter: decrements by 1 each cycle while nonzero. busy = (state!=IDLE), so busy = 1 for exactly LAT cycles, starting with the issue_start cycle.
//  - stall_id = id_valid && id_op in 1..8 && busy (combinational). id_op 0 and ops >8 never stall; ops >8 are never accepted.
//  - Back-to-back: an MFHI/MFLO/MTHI/MTLO/mult/div arriving during busy stalls until the cycle after busy falls.
//    Consecutive MFHI/MTLO-class ops issue every cycle.
//  - req in the issue_start_q cycle: the op is cancelled. The MDU sees no start; state<=IDLE and cnt<=0 at that edge.
//    No accept occurs in the same cycle.
//  - req after the issue cycle: the op is committed; the count continues and busy is unaffected.
//  - ex_ready=0: no accept, so issue_start_q is 0 next cycle. The counter keeps running because the MDU is independent of the pipeline freeze.
//  - Reset mid-operation: returns to the reset state immediately; no pending start survives.
// CONFIGURATION
//  MDU_PERF_CNT_EN defined:
//    - adds output perf_stall_cycles[31:0], which counts cycles with stall_id=1.
//    - clears on reset; wraps at 2**32 to 0.
//  MDU_PERF_CNT_EN undefined:
//    - the port and the counter are absent.
//    - all other behaviour is identical.
// STRUCTURE
//  - Package mdu_pkg:
//      MDU op encoding localparams (MDU_NONE..MDU_MTLO).
//      state enum (IDLE, BUSY_MUL, BUSY_DIV).
//      function is_muldiv(op), true for 1..4.
//  - Sub-module mdu_lat_counter: loadable down-counter (load, load_val, cnt, zero), instantiated once.
//  - The FSM, accept logic and start/stall gating stay in mdu_issue_ctrl.
// TESTING
//  1. Accept MULT: id_valid=1, id_op=1, ex_ready=1 in cycle 0.
//     -> cycle 1: issue_start=1, issue_op=1, cycles_left=5.
//     -> busy=1 for cycles 1..5; busy=0 in cycle 6.
//  2. Present DIV and then MFLO one cycle later (MFLO at cycle 1).
//     -> MFLO: stall_id=1 in cycles 1..10; accepted in cycle 11; issue_start in cycle 12.
//  3. Cancel: req=1 in the issue_start_q cycle of a DIVU.
//     -> issue_start=0; busy=0 and cycles_left=0 on the next cycle.
//     -> the next instruction proceeds without stall.
//  4. Late flush: req=1 in cycle 3 of a MULTU.
//     -> busy stays 1 through cycle 5; cycles_left continues 3,2,1,0.
//  5. Streaming MTHI, MTLO, MFHI on consecutive cycles.
//     -> three consecutive issue_start pulses with issue_op 7, 8, 5; stall_id never 1.
//  6. Reset asserted mid-DIV, at cycles_left=6.
//     -> next cycle: all outputs 0, state IDLE.
//     -> with MDU_PERF_CNT_EN: perf_stall_cycles=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encoding, issue FSM states and op classification helpers.
package mdu_pkg;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_MUL = 2'd1,
      BUSY_DIV = 2'd2
   } mdu_state_e;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op >= MDU_MULT) && (op <= MDU_DIVU);
   endfunction

   function automatic logic is_mdu_op(input logic [3:0] op);
      return (op != MDU_NONE) && (op <= MDU_MTLO);
   endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// Loadable down-counter modelling MDU occupancy; saturates at zero.
module mdu_lat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue controller: accepts ops from ID, pulses start to the MDU, stalls ID while a mult/div runs.
// Optional stall-cycle counter output enabled by defining MDU_PERF_CNT_EN.
module mdu_issue_ctrl
   import mdu_pkg::*;
#(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [3:0]       id_op,
   input  logic             ex_ready,
   input  logic             req,
   output logic             issue_start,
   output logic [3:0]       issue_op,
   output logic             stall_id,
   output logic             busy,
   output logic [CNT_W-1:0] cycles_left
`ifdef MDU_PERF_CNT_EN
   ,
   output logic [31:0]      perf_stall_cycles
`endif
);

   mdu_state_e       state_q, state_d;
   logic             issue_start_q, issue_start_d;
   logic [3:0]       issue_op_q, issue_op_d;
   logic             accept;
   logic             cancel;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;

   assign busy     = (state_q != IDLE);
   assign stall_id = id_valid && is_mdu_op(id_op) && busy;
   assign accept   = id_valid && is_mdu_op(id_op) && !stall_id && ex_ready && !req;
   // A flush in the start cycle kills the op before the MDU ever sees it.
   assign cancel   = issue_start_q && req;

   always_comb begin
      state_d       = state_q;
      issue_start_d = accept;
      issue_op_d    = accept ? id_op : issue_op_q;
      cnt_load      = 1'b0;
      cnt_load_val  = '0;

      case (state_q)
         IDLE: begin
            if (accept && is_muldiv(id_op)) begin
               cnt_load = 1'b1;
               if ((id_op == MDU_DIV) || (id_op == MDU_DIVU)) begin
                  state_d      = BUSY_DIV;
                  cnt_load_val = CNT_W'(DIV_LAT);
               end else begin
                  state_d      = BUSY_MUL;
                  cnt_load_val = CNT_W'(MUL_LAT);
               end
            end
         end
         BUSY_MUL, BUSY_DIV: begin
            if ((cnt == CNT_W'(1)) || cnt_zero) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (cancel) begin
         state_d      = IDLE;
         cnt_load     = 1'b1;
         cnt_load_val = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         issue_start_q <= 1'b0;
         issue_op_q    <= MDU_NONE;
      end else begin
         state_q       <= state_d;
         issue_start_q <= issue_start_d;
         issue_op_q    <= issue_op_d;
      end
   end

   mdu_lat_counter #(.W(CNT_W)) u_lat_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   assign issue_start = issue_start_q & ~req;
   assign issue_op    = issue_op_q;
   assign cycles_left = cnt;

`ifdef MDU_PERF_CNT_EN
   logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;

   always_comb begin
      perf_stall_cycles_d = perf_stall_cycles_q + (stall_id ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_cycles_q <= '0;
      end else begin
         perf_stall_cycles_q <= perf_stall_cycles_d;
      end
   end

   assign perf_stall_cycles = perf_stall_cycles_q;
`endif

endmodule
